// File: rtl/hazard_unit_pkg.sv
// Shared pipeline package for the hazard unit: widths, FSM encoding, redirect payload,
// and the saturating counter helper.
package hazard_unit_pkg;

    localparam int unsigned REG_BITS_DEF = 4;
    localparam int unsigned PC_W         = 16;
    localparam int unsigned CNT_W        = 2;
    localparam int unsigned STAT_W       = 16;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_SHADOW = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] pc;
    } redirect_t;

    // Increment by one when enabled, holding at all-ones.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + STAT_W'(1) : v;
    endfunction

endpackage

// File: rtl/hazard_unit_cmp.sv
// hazard_cmp: purely combinational load-use hazard detector.
// Inputs : decode slot valid / operand-used flags / source regs,
//          execute slot valid / is-load flag / destination reg.
// Output : hazard_c, high when decode reads the register a load in execute will write.
module hazard_cmp #(
    parameter int unsigned REG_BITS = 4
) (
    input  logic                d_valid,
    input  logic                d_uses_a,
    input  logic                d_uses_b,
    input  logic [REG_BITS-1:0] d_rs_a,
    input  logic [REG_BITS-1:0] d_rs_b,
    input  logic                x_valid,
    input  logic                x_is_load,
    input  logic [REG_BITS-1:0] x_rd,
    output logic                hazard_c
);

    logic match_a;
    logic match_b;

    assign match_a  = d_uses_a && (d_rs_a == x_rd);
    assign match_b  = d_uses_b && (d_rs_b == x_rd);
    assign hazard_c = d_valid && x_valid && x_is_load && (match_a || match_b);

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall and taken-branch flush/redirect control.
// Ports : clk, rst (async active-high); decode d_* and execute x_* slot info;
//         br_taken/br_target from execute; stall, flush, redirect_valid, redirect_pc,
//         stall_cnt (stall cycles remaining after the current cycle).
// Stall/flush/redirect react in the same cycle, so they are combinational and are forced
// to zero while rst is high.
// Option: define HAZARD_UNIT_STATS_EN to add saturating stall_cycles / flush_count outputs.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned REG_BITS  = REG_BITS_DEF,
    parameter int unsigned MAX_STALL = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                d_valid,
    input  logic                d_uses_a,
    input  logic                d_uses_b,
    input  logic [REG_BITS-1:0] d_rs_a,
    input  logic [REG_BITS-1:0] d_rs_b,
    input  logic                x_valid,
    input  logic                x_is_load,
    input  logic [REG_BITS-1:0] x_rd,
    input  logic                br_taken,
    input  logic [PC_W-1:0]     br_target,
    output logic                stall,
    output logic                flush,
    output logic                redirect_valid,
    output logic [PC_W-1:0]     redirect_pc,
    output logic [CNT_W-1:0]    stall_cnt
`ifdef HAZARD_UNIT_STATS_EN
    ,
    output logic [STAT_W-1:0]   stall_cycles,
    output logic [STAT_W-1:0]   flush_count
`endif
);

    localparam logic [CNT_W-1:0] FIRST_REM = CNT_W'(MAX_STALL - 1);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hazard_c;
    redirect_t        redir_c;

    hazard_cmp #(.REG_BITS(REG_BITS)) u_cmp (
        .d_valid   (d_valid),
        .d_uses_a  (d_uses_a),
        .d_uses_b  (d_uses_b),
        .d_rs_a    (d_rs_a),
        .d_rs_b    (d_rs_b),
        .x_valid   (x_valid),
        .x_is_load (x_is_load),
        .x_rd      (x_rd),
        .hazard_c  (hazard_c)
    );

    // State and remaining-stall register; cnt_q holds the stall cycles still owed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and same-cycle outputs; a taken branch overrides everything.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall     = 1'b0;
        stall_cnt = '0;
        redir_c   = '0;
        flush     = 1'b0;
        if (!rst) begin
            if (br_taken) begin
                flush         = 1'b1;
                redir_c.valid = 1'b1;
                redir_c.pc    = br_target;
                cnt_d         = '0;
                state_d       = ST_SHADOW;
            end else begin
                unique case (state_q)
                    ST_RUN: begin
                        if (hazard_c) begin
                            stall     = 1'b1;
                            stall_cnt = FIRST_REM;
                            if (MAX_STALL > 1) begin
                                cnt_d   = FIRST_REM;
                                state_d = ST_STALL;
                            end
                        end
                    end
                    ST_STALL: begin
                        stall     = 1'b1;
                        stall_cnt = cnt_q - CNT_W'(1);
                        cnt_d     = cnt_q - CNT_W'(1);
                        if (cnt_d == '0) begin
                            state_d = ST_RUN;
                        end
                    end
                    ST_SHADOW: begin
                        // Wrong-path decode: hazard detection suppressed for this cycle.
                        state_d = ST_RUN;
                    end
                    default: begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    assign redirect_valid = redir_c.valid;
    assign redirect_pc    = redir_c.pc;

`ifdef HAZARD_UNIT_STATS_EN
    // Saturating event counters for stall and flush cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            stall_cycles <= sat_inc(stall_cycles, stall);
            flush_count  <= sat_inc(flush_count, flush);
        end
    end
`endif

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter REG_BITS, default 4: register-index width.
REQ-002 SHALL have parameter MAX_STALL, default 2: total stall cycles per load-use hazard, legal 1..2, matching the 2-deep fetch stall buffer.
REQ-003 SHALL have port clk  input  1  the single clock; all state on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports d_valid/d_uses_a/d_uses_b  input  1 each  decode slot valid and source-operand-used flags.
REQ-006 SHALL have ports d_rs_a/d_rs_b  input  REG_BITS each  decode source registers.
REQ-007 SHALL have ports x_valid/x_is_load  input  1 each  execute slot valid and is-load flags.
REQ-008 SHALL have port x_rd  input  REG_BITS  execute destination register.
REQ-009 SHALL have port br_taken  input  1  taken branch resolved in execute this cycle.
REQ-010 SHALL have port br_target  input  16  branch target PC.
REQ-011 SHALL have port stall  output  1  hold fetch/decode; drives the fetch stall buffer.
REQ-012 SHALL have port flush  output  1  kill younger instructions; drives the fetch stall buffer.
REQ-013 SHALL have ports redirect_valid  output  1  and redirect_pc  output  16  fetch redirect.
REQ-014 SHALL have port stall_cnt  output  2  stall cycles remaining after the current cycle.

Function
REQ-015 SHALL define hazard = d_valid & x_valid & x_is_load & ((d_uses_a & d_rs_a==x_rd) | (d_uses_b & d_rs_b==x_rd)).
REQ-016 SHALL implement FSM states RUN, STALL, SHADOW; reset state RUN.
REQ-017 RUN: hazard & !br_taken SHALL assert stall combinationally the same cycle, load stall_cnt <= MAX_STALL-1 and go to STALL if MAX_STALL>1, else stay RUN.
REQ-018 STALL: stall SHALL be 1 regardless of decode inputs; stall_cnt decrements each cycle; transition to RUN on the cycle stall_cnt reaches 0.
REQ-019 Consecutive stall cycles per hazard SHALL never exceed MAX_STALL; a new hazard detected on the first RUN cycle after STALL starts a fresh stall.
REQ-020 br_taken in any state SHALL assert flush=1 and redirect_valid=1 with redirect_pc=br_target that cycle, force stall=0, clear stall_cnt and go to SHADOW.
REQ-021 SHADOW SHALL last exactly one cycle with hazard detection suppressed (wrong-path decode), then go to RUN; br_taken in SHADOW re-flushes and stays SHADOW.
REQ-022 flush/redirect_valid SHALL be 1-cycle pulses per br_taken cycle; redirect_pc SHALL be 0 when redirect_valid=0.
REQ-023 br_taken and hazard in the same cycle: flush SHALL win, stall=0.

Reset
REQ-024 While rst=1: stall=0, flush=0, redirect_valid=0, redirect_pc=0, stall_cnt=0, state RUN, counters 0, regardless of inputs.
REQ-025 rst asserted mid-STALL SHALL abort the stall immediately (asynchronously); first cycle after release is RUN.

Configuration
REQ-026 Macro HAZARD_UNIT_STATS_EN defined: SHALL add outputs stall_cycles (16) and flush_count (16), counting cycles with stall=1 and cycles with flush=1, saturating at 16'hFFFF, cleared by rst.
REQ-027 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-028 FSM state encoding, REG_BITS default and PC width 16 SHALL live in the shared pipeline package.
REQ-029 Hazard comparison SHALL be one sub-module hazard_cmp (purely combinational); FSM and counters in hazard_unit.

Verification
REQ-030 MAX_STALL=2, x load rd=3, decode uses rs_a=3 -> stall=1 two cycles, stall_cnt 1 then 0, then stall=0.
REQ-031 Load rd=3, decode rs_a=3 with d_uses_a=0 -> stall stays 0.
REQ-032 br_taken=1, br_target=16'h0040 concurrent with a hazard -> flush=1, redirect_pc=16'h0040, stall=0; next cycle SHADOW ignores a hazard.
REQ-033 br_taken on second STALL cycle -> stall drops that cycle, flush=1, stall_cnt=0.
REQ-034 rst pulsed mid-STALL -> stall=0 immediately; after release, a new hazard stalls a full 2 cycles.
REQ-035 With HAZARD_UNIT_STATS_EN: two hazards and one branch -> stall_cycles=4, flush_count=1.
